// File: rtl/bt_pipe_pkg.sv
// Shared definitions for the block-throttled pipe-in buffer: default data
// width, output-stage state encoding and a counter-width helper.
package bt_pipe_pkg;

    localparam int DATA_W_DEF = 32;

    // Output stage: nothing held, RAM read in flight, word presented.
    typedef enum logic [1:0] {
        OUT_EMPTY    = 2'd0,
        OUT_PREFETCH = 2'd1,
        OUT_VALID    = 2'd2
    } out_state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bt_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// one-cycle latency. The array has no reset. The read data register only
// changes when a read is issued, so it can serve as a holding stage.
module bt_fifo_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
    logic [DATA_W-1:0] r_rd_data;

    // Write port and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bt_pipe_in_buffer.sv
// Elastic buffer between the block-throttled pipe-in endpoint and the
// downstream valid/ready consumer. Words are stored in a synchronous-read
// RAM and presented through an output register; capacity counts that
// register. pipe_in_ready means a whole block of free space exists.
//
// Optional statistics (block_count, max_fill) are built only when the
// macro BT_PIPE_IN_BUF_STATS_EN is defined; otherwise both read as 0.
//
// Downstream handshake: a word transfers on a cycle where m_valid and
// m_ready are both high; m_valid never drops and m_data never changes
// while a word is waiting for m_ready.
module bt_pipe_in_buffer
    import bt_pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_in_write,
    input  logic [DATA_W-1:0]     pipe_in_data,
    output logic                  pipe_in_ready,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [31:0]           overflow_count,
    output logic [31:0]           block_count,
    output logic [DEPTH_LOG2:0]   max_fill,
    output logic [1:0]            dbg_out_state
);

    localparam logic [DEPTH_LOG2:0] CAP = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] BLK = (DEPTH_LOG2+1)'(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);

    if (BLOCK_WORDS < 1 || BLOCK_WORDS > (2**DEPTH_LOG2)) begin : g_bad_block_words
        $error("BLOCK_WORDS must lie in 1..2**DEPTH_LOG2");
    end

    // Pointers carry one extra bit so a completely full RAM differs from empty.
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH_LOG2:0] r_fill;
    logic                r_ready;
    logic [31:0]         r_ovf;
    out_state_t          r_state;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    // RAM read register holds the word following the one in r_m_data.
    logic                r_ahead;

    logic                w_accept;
    logic                w_drop;
    logic                w_hs;
    logic                w_ram_empty;
    logic                w_rd_en;
    logic [DEPTH_LOG2:0] w_fill_next;
    logic [DATA_W-1:0]   w_rd_data;

    // Write acceptance, handshake and next fill; full check uses pre-cycle fill.
    always_comb begin
        w_accept    = pipe_in_write && (r_fill < CAP);
        w_drop      = pipe_in_write && (r_fill == CAP);
        w_hs        = r_m_valid && m_ready;
        w_ram_empty = (r_wr_ptr == r_rd_ptr);
        w_fill_next = r_fill + (w_accept ? ONE : '0) - (w_hs ? ONE : '0);
    end

    // RAM read issue: fetch the head, then keep one word read ahead.
    always_comb begin
        w_rd_en = 1'b0;
        case (r_state)
            OUT_EMPTY:    w_rd_en = !w_ram_empty;
            OUT_PREFETCH: w_rd_en = !w_ram_empty;
            OUT_VALID:    w_rd_en = !w_ram_empty && (w_hs || !r_ahead);
            default:      w_rd_en = 1'b0;
        endcase
    end

    bt_fifo_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wr_data (pipe_in_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Write side: pointer, fill level, block-space flag and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_ready  <= 1'b1;
            r_ovf    <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            r_fill  <= w_fill_next;
            r_ready <= ((CAP - w_fill_next) >= BLK);
            if (w_drop && (r_ovf != 32'hFFFF_FFFF)) begin
                r_ovf <= r_ovf + 32'd1;
            end
        end
    end

    // Output FSM: moves words from the RAM into the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= OUT_EMPTY;
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_ahead   <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            case (r_state)
                OUT_EMPTY: begin
                    if (w_rd_en) begin
                        r_state <= OUT_PREFETCH;
                    end
                end
                OUT_PREFETCH: begin
                    r_m_data  <= w_rd_data;
                    r_m_valid <= 1'b1;
                    r_ahead   <= w_rd_en;
                    r_state   <= OUT_VALID;
                end
                OUT_VALID: begin
                    if (w_hs) begin
                        if (r_ahead) begin
                            r_m_data <= w_rd_data;
                            r_ahead  <= w_rd_en;
                        end else begin
                            r_m_valid <= 1'b0;
                            r_state   <= w_rd_en ? OUT_PREFETCH : OUT_EMPTY;
                        end
                    end else if (w_rd_en) begin
                        r_ahead <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= OUT_EMPTY;
                    r_m_valid <= 1'b0;
                    r_ahead   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BT_PIPE_IN_BUF_STATS_EN
    localparam int BCW = cnt_w(BLOCK_WORDS);

    logic [BCW-1:0]      r_blk_words;
    logic [31:0]         r_blk_cnt;
    logic [DEPTH_LOG2:0] r_max_fill;

    // Completed-block counter over accepted writes and fill high-water mark.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_words <= '0;
            r_blk_cnt   <= '0;
            r_max_fill  <= '0;
        end else begin
            if (w_accept) begin
                if (r_blk_words == BCW'(BLOCK_WORDS - 1)) begin
                    r_blk_words <= '0;
                    r_blk_cnt   <= r_blk_cnt + 32'd1;
                end else begin
                    r_blk_words <= r_blk_words + BCW'(1);
                end
            end
            if (w_fill_next > r_max_fill) begin
                r_max_fill <= w_fill_next;
            end
        end
    end

    assign block_count = r_blk_cnt;
    assign max_fill    = r_max_fill;
`else
    assign block_count = '0;
    assign max_fill    = '0;
`endif

    // Ready is forced low while reset is held and high as soon as it drops.
    assign pipe_in_ready  = r_ready && !reset;
    assign m_valid        = r_m_valid;
    assign m_data         = r_m_data;
    assign fill_level     = r_fill;
    assign overflow_count = r_ovf;
    assign dbg_out_state  = r_state;

endmodule

// File: tb/tb_bt_pipe_in_buffer.sv
// Self-checking bench for bt_pipe_in_buffer (DEPTH 1024, BLOCK 256).
// A queue-based model tracks what the buffer must hold; a negedge process
// compares every output against it each cycle. Directed phases pin
// latency, block-throttle and overflow behaviour with literal values.
module tb_bt_pipe_in_buffer;
  import bt_pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int DL     = 10;
  localparam int BLK    = 256;
  localparam int CAP    = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pipe_in_write = 1'b0;
  logic [DATA_W-1:0] pipe_in_data = '0;
  logic              m_ready = 1'b0;
  logic              pipe_in_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [DL:0]       fill_level;
  logic [31:0]       overflow_count;
  logic [31:0]       block_count;
  logic [DL:0]       max_fill;
  logic [1:0]        dbg_out_state;

  always #5 clk = ~clk;

  bt_pipe_in_buffer #(
    .DATA_W      (DATA_W),
    .DEPTH_LOG2  (DL),
    .BLOCK_WORDS (BLK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_in_write  (pipe_in_write),
    .pipe_in_data   (pipe_in_data),
    .pipe_in_ready  (pipe_in_ready),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .fill_level     (fill_level),
    .overflow_count (overflow_count),
    .block_count    (block_count),
    .max_fill       (max_fill),
    .dbg_out_state  (dbg_out_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [31:0]       m_ovf = '0;
  bit                m_rdy = 1'b1;
  int                m_blocks = 0;
  int                m_blk_words = 0;
  int                m_max = 0;
  int                hs_count = 0;
  int                cyc = 0;
  bit                chk_en = 1'b0;
  int                first_valid_cyc = -1;
  int                low_run = 0;
  int                errors = 0;
  int                checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: applies the buffer rules to the inputs sampled at each edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_ovf = '0;
      m_rdy = 1'b1;
      m_blocks = 0;
      m_blk_words = 0;
      m_max = 0;
    end else begin
      bit was_full;
      was_full = (exp_q.size() >= CAP);
      if (m_valid && m_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hs_count++;
      end
      if (pipe_in_write) begin
        if (!was_full) begin
          exp_q.push_back(pipe_in_data);
          m_blk_words++;
          if (m_blk_words == BLK) begin
            m_blk_words = 0;
            m_blocks++;
          end
        end else if (m_ovf != 32'hFFFF_FFFF) begin
          m_ovf = m_ovf + 32'd1;
        end
      end
      m_rdy = ((CAP - exp_q.size()) >= BLK);
      if (exp_q.size() > m_max) m_max = exp_q.size();
    end
  end

  // Compare process: every output against the model, once per cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("fill_level", fill_level, exp_q.size());
      check("pipe_in_ready", pipe_in_ready, (reset ? 1'b0 : m_rdy));
      check("overflow_count", overflow_count, m_ovf);
      if (m_valid) begin
        check("m_valid_with_data", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("m_data", m_data, exp_q[0]);
        check("state_when_valid", dbg_out_state, OUT_VALID);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (!m_valid && exp_q.size() > 0 && !reset) low_run++;
      else low_run = 0;
      check("m_valid_wait_le2", low_run > 2, 0);
`ifdef BT_PIPE_IN_BUF_STATS_EN
      check("block_count", block_count, m_blocks);
      check("max_fill", max_fill, m_max);
`else
      check("block_count_off", block_count, 0);
      check("max_fill_off", max_fill, 0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pipe_in_write = 1'b0;
    m_ready = 1'b0;
    tick();
    check("ready_in_reset", pipe_in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("ready_after_reset", pipe_in_ready, 1);
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    pipe_in_write = 1'b1;
    pipe_in_data = d;
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    pipe_in_write = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < budget && fill_level != 0; i++) tick();
    check(name, fill_level, 0);
    m_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int start_cyc;
    int hs_start;
    int total_wr;
    int guard;

    tick();
    chk_en = 1'b1;
    do_reset();
    tick();
    tick();
    // Idle after reset.
    check("idle_ready", pipe_in_ready, 1);
    check("idle_m_valid", m_valid, 0);
    check("idle_fill", fill_level, 0);
    check("idle_state", dbg_out_state, OUT_EMPTY);

    // Stream 1..256 with the consumer always ready.
    m_ready = 1'b1;
    first_valid_cyc = -1;
    start_cyc = cyc;
    hs_start = hs_count;
    for (int i = 1; i <= BLK; i++) write_word(DATA_W'(i));
    drain("t2_drained", 50);
    // Write sampled on edge start_cyc+1, m_valid seen after edge start_cyc+3.
    check("first_valid_latency", first_valid_cyc - start_cyc, 3);
    check("t2_words_out", hs_count - hs_start, BLK);
    check("t2_overflow", overflow_count, 0);
`ifdef BT_PIPE_IN_BUF_STATS_EN
    check("t2_block_count", block_count, 1);
    check("t2_max_fill_small", max_fill <= 3, 1);
`endif

    // Fill with the consumer stalled: watch ready fall and overflow.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 768; i++) write_word($urandom);
    check("fill_768", fill_level, 768);
    check("ready_at_free_256", pipe_in_ready, 1);
    write_word($urandom);
    check("fill_769", fill_level, 769);
    check("ready_at_free_255", pipe_in_ready, 0);
    for (int i = 769; i < CAP + 4; i++) write_word($urandom);
    pipe_in_write = 1'b0;
    tick();
    check("full_overflow_4", overflow_count, 4);
    check("full_fill", fill_level, CAP);
    check("full_m_valid", m_valid, 1);

    // Full: write and read together -> write dropped, one word leaves.
    pipe_in_write = 1'b1;
    pipe_in_data = 32'hDEAD_BEEF;
    m_ready = 1'b1;
    tick();
    pipe_in_write = 1'b0;
    m_ready = 1'b0;
    check("full_rw_overflow", overflow_count, 5);
    check("full_rw_fill", fill_level, CAP - 1);
    drain("t4_drained", 1200);

    // Random bursts, each started only while a block of space is offered.
    do_reset();
    total_wr = 0;
    guard = 0;
    while (total_wr < 10000 && guard < 60000) begin
      if (pipe_in_ready) begin
        int len;
        len = $urandom_range(1, BLK);
        for (int j = 0; j < len; j++) begin
          pipe_in_write = ($urandom_range(0, 3) != 0);
          pipe_in_data = $urandom;
          m_ready = ($urandom_range(0, 3) != 0);
          if (pipe_in_write) total_wr++;
          tick();
          guard++;
        end
        pipe_in_write = 1'b0;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
        tick();
        guard++;
      end
    end
    check("random_enough_words", total_wr >= 10000, 1);
    check("random_no_drops", overflow_count, 0);

    // Reset while data is buffered and writes keep coming.
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) write_word($urandom);
    check("pre_reset_fill_nonzero", fill_level != 0, 1);
    reset = 1'b1;
    tick();
    check("mid_reset_fill", fill_level, 0);
    check("mid_reset_m_valid", m_valid, 0);
    check("mid_reset_max_fill", max_fill, 0);
    check("mid_reset_block_count", block_count, 0);
    reset = 1'b0;
    pipe_in_write = 1'b0;
    for (int i = 0; i < 5; i++) write_word(DATA_W'(32'hA000 + i));
    drain("post_reset_drained", 50);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
